obi_str_reader: RTL and testbench
=================================

Name: obi_str_reader

Overview:
- OBI manager that fetches a NUL-terminated byte string from any OBI subordinate.
- Targets include the user-domain ROM and SRAM.
- Fetched bytes are presented on a valid/ready byte stream (UART TX feeder, debug console).
- Sits in the user domain and connects to a user-domain manager port of the OBI crossbar.
- Read-only: exactly one outstanding transaction; tolerates any grant or response latency.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration (AddrWidth, DataWidth=32, IdWidth).
- obi_req_t, logic, OBI request struct type.
- obi_rsp_t, logic, OBI response struct type.
- MaxWords, 8, maximum 32-bit words fetched per string (1..256).
- TimeoutCycles, 16, response timeout in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  start pulse; sampled only in IDLE.
- base_addr_i  in  AddrWidth  string start address; word-aligned, bits [1:0] ignored.
- obi_req_o  out  obi_req_t  OBI request to subordinate.
- obi_rsp_i  in  obi_rsp_t  OBI response from subordinate.
- byte_o  out  8  current string byte.
- byte_valid_o  out  1  byte_o valid.
- byte_ready_i  in  1  consumer accepts byte.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse at end of string, word limit, or error.
- err_o  out  1  sticky error flag; cleared on accepted start_i.

Behaviour:
- Reset values: all outputs 0; req=0, addr=0, we=0, be=0, aid=0, wdata=0. FSM in IDLE; word index, byte index and data register cleared.
- FSM states: IDLE, REQ, WAIT, DRAIN, DONE.
- IDLE:
  - start_i=1 → latch {base_addr_i[AW-1:2],2'b00}, clear word_idx and err_o, go to REQ.
  - start_i is ignored in every other state.
- REQ:
  - Drive req=1, we=0, be=4'hF, aid=0, wdata=0, addr=base+4*word_idx.
  - Hold all fields stable until gnt=1.
  - In the gnt cycle → WAIT.
- WAIT:
  - req=0.
  - On rvalid=1: capture rdata into the word register and set byte_idx=0.
  - r.err=1 → set err_o, go to DONE (no bytes emitted from that word). Otherwise go to DRAIN.
  - rvalid in the same cycle as gnt is legal and handled (transition directly REQ → DRAIN/DONE).
- DRAIN:
  - Little-endian order: byte_o = word[8*byte_idx +: 8], byte 0 first.
  - If the current byte is 8'h00: do not assert byte_valid_o; go to DONE.
  - Otherwise assert byte_valid_o. On byte_valid_o & byte_ready_i, increment byte_idx.
  - byte_o and byte_valid_o stay stable while byte_ready_i=0.
  - After byte 3 is accepted: word_idx+1. If that equals MaxWords → DONE, else → REQ.
- DONE: done_o=1 for exactly one cycle, busy_o=0 next cycle, return to IDLE.
- Address arithmetic: AddrWidth bits, wraps modulo 2^AddrWidth with no error.
- word_idx is wide enough to hold MaxWords.
- Stray rvalid outside WAIT is ignored.
- Reset mid-transaction returns everything to reset values immediately; an in-flight response is dropped.
- Latency: start → first req is 1 cycle. With zero-wait gnt and 2-cycle rvalid, first byte_valid_o appears 4 cycles after start.

Optional Feature:
- Macro: OBI_STR_READER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT. If rvalid is not seen within TimeoutCycles cycles after gnt, set err_o and go to DONE.
  - A later stray rvalid is ignored.
  - The counter resets on every entry to WAIT.
- Not defined: WAIT blocks indefinitely and TimeoutCycles is unused; no counter logic is present.

Test Plan:
- Against user ROM (2-cycle latency, gnt=req), base 0x0, byte_ready_i=1 → 25 bytes 54 2E 50 49 47 4E 49 41 4E 44 43 2E 44 55 48 52 41 27 73 20 41 53 49 43 0A. Then NUL stops the stream: done_o pulses once, err_o=0, exactly 7 OBI reads.
- MaxWords=2, base 0x0 → exactly 8 bytes (54 2E 50 49 47 4E 49 41). Then done_o, 2 reads, no NUL seen.
- Backpressure: byte_ready_i=0 for 5 cycles on the 3rd byte → byte_o=0x50 with byte_valid_o=1 held stable. No further OBI request until the word drains; the sequence is unchanged.
- Subordinate returns r.err=1 on the 2nd read → 4 bytes emitted, then err_o=1 and done_o pulse. The next start_i clears err_o.
- start_i pulsed while busy_o=1 → ignored: no address change, single done_o. Reset asserted in WAIT → all outputs 0 the same cycle, FSM in IDLE.
- With OBI_STR_READER_TIMEOUT_EN, TimeoutCycles=16, subordinate never asserts rvalid → err_o=1 and done_o 16 cycles after gnt. Without the macro, busy_o stays 1 for 100 cycles.

Source files
------------

// File: rtl/obi_str_reader.sv
// OBI read manager: fetches a NUL-terminated string word by word and streams its bytes (LSB first).
// Optional feature macro OBI_STR_READER_TIMEOUT_EN adds a response timeout in WAIT.
package obi_str_reader_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [0:0]  aid;
        logic [31:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

// state | meaning
// IDLE  | waiting for start_i
// REQ   | request held until granted
// WAIT  | granted, waiting for rvalid
// DRAIN | streaming bytes of the captured word
// DONE  | one-cycle done_o pulse
module obi_str_reader #(
    parameter obi_str_reader_pkg::obi_cfg_t ObiCfg = obi_str_reader_pkg::ObiDefaultConfig,
    parameter type obi_req_t = obi_str_reader_pkg::obi_req_t,
    parameter type obi_rsp_t = obi_str_reader_pkg::obi_rsp_t,
    parameter int unsigned MaxWords = 8,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic [ObiCfg.AddrWidth-1:0] base_addr_i,
    output obi_req_t                    obi_req_o,
    input  obi_rsp_t                    obi_rsp_i,
    output logic [7:0]                  byte_o,
    output logic                        byte_valid_o,
    input  logic                        byte_ready_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);
    localparam int unsigned AW  = ObiCfg.AddrWidth;
    localparam int unsigned WIW = $clog2(MaxWords + 1);

    if (MaxWords < 1 || MaxWords > 256 || TimeoutCycles < 1 || ObiCfg.DataWidth != 32) begin : g_bad_cfg
        $error("obi_str_reader: unsupported parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_e;

    state_e         r_state;
    state_e         w_state_nxt;
    logic [AW-1:0]  r_base;
    logic [WIW-1:0] r_word_idx;
    logic [1:0]     r_byte_idx;
    logic [31:0]    r_word;
    logic           r_err;

    logic [AW-1:0]  w_addr;
    logic [7:0]     w_cur_byte;
    logic           w_take_rsp;
    logic           w_byte_acc;
    logic           w_last_word;
    logic           w_timeout;
    logic           w_unused_rid;

    assign w_addr       = r_base + (AW'(r_word_idx) << 2);
    assign w_cur_byte   = r_word[{r_byte_idx, 3'b000} +: 8];
    // A response in the grant cycle itself is taken straight from REQ.
    assign w_take_rsp   = obi_rsp_i.rvalid &&
                          ((r_state == S_WAIT) || (r_state == S_REQ && obi_rsp_i.gnt));
    assign w_byte_acc   = (r_state == S_DRAIN) && (w_cur_byte != 8'h00) && byte_ready_i;
    assign w_last_word  = (r_word_idx + WIW'(1)) == WIW'(MaxWords);
    assign w_unused_rid = ^obi_rsp_i.r.rid;

`ifdef OBI_STR_READER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] r_tmo_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_REQ) begin
            r_tmo_cnt <= TW'(TimeoutCycles - 1);
        end else if (r_state == S_WAIT && r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - TW'(1);
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !obi_rsp_i.rvalid && (r_tmo_cnt == '0);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (obi_rsp_i.gnt) begin
                    if (obi_rsp_i.rvalid) w_state_nxt = obi_rsp_i.r.err ? S_DONE : S_DRAIN;
                    else                  w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (obi_rsp_i.rvalid) w_state_nxt = obi_rsp_i.r.err ? S_DONE : S_DRAIN;
                else if (w_timeout)   w_state_nxt = S_DONE;
            end
            S_DRAIN: begin
                if (w_cur_byte == 8'h00)                   w_state_nxt = S_DONE;
                else if (w_byte_acc && r_byte_idx == 2'd3) w_state_nxt = w_last_word ? S_DONE : S_REQ;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_base     <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start_i) begin
                r_base     <= {base_addr_i[AW-1:2], 2'b00};
                r_word_idx <= '0;
                r_err      <= 1'b0;
            end
            if (w_take_rsp) begin
                r_word     <= obi_rsp_i.r.rdata;
                r_byte_idx <= '0;
                if (obi_rsp_i.r.err) r_err <= 1'b1;
            end
            if (w_timeout) r_err <= 1'b1;
            if (w_byte_acc) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd3) r_word_idx <= r_word_idx + WIW'(1);
            end
        end
    end

    always_comb begin
        obi_req_o    = '0;
        byte_o       = 8'h00;
        byte_valid_o = 1'b0;
        busy_o       = (r_state != S_IDLE);
        done_o       = (r_state == S_DONE);
        if (r_state == S_REQ) begin
            obi_req_o.req    = 1'b1;
            obi_req_o.a.addr = w_addr;
            obi_req_o.a.be   = 4'hF;
        end
        if (r_state == S_DRAIN && w_cur_byte != 8'h00) begin
            byte_o       = w_cur_byte;
            byte_valid_o = 1'b1;
        end
    end

    assign err_o = r_err;
endmodule

// File: tb/tb_obi_str_reader.sv
// Bench for obi_str_reader: table vectors, hand sequences and random strings vs a queue-based model.
module tb_obi_str_reader;
    import obi_str_reader_pkg::*;

    localparam int MAXW = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    obi_req_t    obi_req;
    obi_rsp_t    obi_rsp;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        byte_ready_i = 1'b1;
    logic        busy_o, done_o, err_o;

    always #5 clk_i = ~clk_i;

    obi_str_reader #(.MaxWords(MAXW), .TimeoutCycles(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
        .obi_req_o(obi_req), .obi_rsp_i(obi_rsp),
        .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Subordinate: 256-byte memory aliased over the whole address space.
    logic [7:0] mem [256];
    int cfg_gwait = 0, cfg_rlat = 2, cfg_err_idx = -1, err_base = 0;
    int gcnt = 0, pcnt = 0, sub_reads = 0;
    logic pend = 1'b0, perr = 1'b0;
    logic [31:0] paddr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int i;
        i = int'(a[7:2]) * 4;
        return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
    endfunction

    always_comb begin
        obi_rsp = '0;
        obi_rsp.gnt = obi_req.req && (gcnt >= cfg_gwait);
        if (pend && pcnt == 0) begin
            obi_rsp.rvalid  = 1'b1;
            obi_rsp.r.rdata = mem_word(paddr);
            obi_rsp.r.err   = perr;
        end else if (obi_rsp.gnt && cfg_rlat == 0) begin
            obi_rsp.rvalid  = 1'b1;
            obi_rsp.r.rdata = mem_word(obi_req.a.addr);
            obi_rsp.r.err   = ((sub_reads - err_base) == cfg_err_idx);
        end
    end

    always @(posedge clk_i) begin
        if (obi_req.req && !obi_rsp.gnt) gcnt <= gcnt + 1;
        else                             gcnt <= 0;
        if (pend && pcnt == 0) pend <= 1'b0;
        else if (pend)         pcnt <= pcnt - 1;
        if (obi_req.req && obi_rsp.gnt) begin
            sub_reads <= sub_reads + 1;
            if (cfg_rlat > 0) begin
                pend  <= 1'b1;
                pcnt  <= cfg_rlat - 1;
                paddr <= obi_req.a.addr;
                perr  <= ((sub_reads - err_base) == cfg_err_idx);
            end
        end
    end

    // Consumer + monitor: ready decided first, then acceptance recorded with that ready.
    int rmode = 0, stall_left = 0, obs_done = 0;
    logic [7:0]  obs_b[$];
    logic [31:0] obs_a[$];

    always @(negedge clk_i) begin
        case (rmode)
            0: byte_ready_i = 1'b1;
            1: byte_ready_i = ($urandom_range(0, 2) != 0);
            default: begin
                if (byte_valid_o && byte_o == 8'h50 && stall_left > 0) begin
                    byte_ready_i = 1'b0;
                    stall_left--;
                    check("bp_no_req", obi_req.req, 1'b0);
                end else begin
                    byte_ready_i = 1'b1;
                end
            end
        endcase
        if (byte_valid_o && byte_ready_i) obs_b.push_back(byte_o);
        if (obi_req.req && obi_rsp.gnt) begin
            obs_a.push_back(obi_req.a.addr);
            check("req_fields", {obi_req.a.we, obi_req.a.be, obi_req.a.aid, obi_req.a.wdata},
                  {1'b0, 4'hF, 1'b0, 32'h0});
        end
        if (done_o) obs_done++;
    end

    // Reference model: walk words from the aligned base, stop on NUL, error or word limit.
    logic [7:0]  exp_b[$];
    logic [31:0] exp_a[$];
    bit exp_err;

    task automatic model(input logic [31:0] base, input int err_idx);
        logic [31:0] a, ak;
        bit stop;
        stop = 0;
        exp_b.delete(); exp_a.delete(); exp_err = 0;
        for (int w = 0; w < MAXW && !stop; w++) begin
            a = {base[31:2], 2'b00} + 32'(4 * w);
            exp_a.push_back(a);
            if (w == err_idx) begin
                exp_err = 1; stop = 1;
            end else begin
                for (int k = 0; k < 4 && !stop; k++) begin
                    ak = a + 32'(k);
                    if (mem[ak[7:0]] == 8'h00) stop = 1;
                    else exp_b.push_back(mem[ak[7:0]]);
                end
            end
        end
    endtask

    int first_lat;

    task automatic run(input logic [31:0] base, input int err_idx, input int rlat, input int gwait,
                       input int mode, input int restart_at, input string tag);
        int cyc;
        cfg_rlat = rlat; cfg_gwait = gwait; cfg_err_idx = err_idx; err_base = sub_reads;
        rmode = mode; stall_left = (mode == 2) ? 5 : 0;
        model(base, err_idx);
        obs_b.delete(); obs_a.delete(); obs_done = 0; first_lat = -1;
        base_addr_i = base; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; base_addr_i = $urandom;
        check({tag, "_req_1cyc"}, obi_req.req, 1'b1);
        check({tag, "_err_clr"}, err_o, 1'b0);
        cyc = 0;
        while (obs_done == 0 && cyc < 3000) begin
            if (byte_valid_o && first_lat < 0) first_lat = cyc + 1;
            if (restart_at > 0 && cyc == restart_at) begin
                start_i = 1'b1; base_addr_i = 32'h80;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check({tag, "_finished"}, obs_done > 0, 1'b1);
        check({tag, "_done_cnt"}, obs_done, 1);
        check({tag, "_nbytes"}, obs_b.size(), exp_b.size());
        for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) check({tag, "_byte"}, obs_b[i], exp_b[i]);
        check({tag, "_nreads"}, obs_a.size(), exp_a.size());
        for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) check({tag, "_addr"}, obs_a[i], exp_a[i]);
        check({tag, "_err"}, err_o, exp_err);
        check({tag, "_idle"}, busy_o, 1'b0);
        if (mode == 2) check({tag, "_bp_held5"}, stall_left, 0);
    endtask

    typedef struct {
        logic [31:0] base;
        int err_idx, rlat, gwait, mode, restart;
        int nb, nr;
        bit er;
        string tag;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] base, input int err_idx, input int rlat, input int gwait,
                                input int mode, input int restart, input int nb, input int nr,
                                input bit er, input string tag);
        vec_t v;
        v.base = base; v.err_idx = err_idx; v.rlat = rlat; v.gwait = gwait; v.mode = mode;
        v.restart = restart; v.nb = nb; v.nr = nr; v.er = er; v.tag = tag;
        return v;
    endfunction

    task automatic reset_pulse();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        vec_t vecs[$];
        logic [7:0] rom [25];
        int nbusy;

        rom = '{8'h54, 8'h2E, 8'h50, 8'h49, 8'h47, 8'h4E, 8'h49, 8'h41, 8'h4E, 8'h44, 8'h43, 8'h2E,
                8'h44, 8'h55, 8'h48, 8'h52, 8'h41, 8'h27, 8'h73, 8'h20, 8'h41, 8'h53, 8'h49, 8'h43, 8'h0A};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 25; i++) mem[i] = rom[i];
        for (int i = 0; i < 32; i++) mem[8'h40 + i] = 8'(8'h61 + i);
        mem[8'h88] = 8'h41; mem[8'h89] = 8'h42; mem[8'h8A] = 8'h00; mem[8'h8B] = 8'h43;
        for (int i = 0; i < 8; i++) mem[8'hF8 + i] = 8'(8'h30 + i);

        vecs.push_back(mk(32'h0000_0000, -1, 2, 0, 0, 0, 25, 7, 1'b0, "rom"));
        vecs.push_back(mk(32'h0000_0000, -1, 2, 0, 2, 0, 25, 7, 1'b0, "backpressure"));
        vecs.push_back(mk(32'h0000_0000,  1, 2, 0, 0, 0,  4, 2, 1'b1, "err_2nd"));
        vecs.push_back(mk(32'h0000_0088, -1, 0, 0, 0, 0,  2, 1, 1'b0, "same_cyc_rsp"));
        vecs.push_back(mk(32'h0000_0040, -1, 1, 2, 1, 0, 32, 8, 1'b0, "word_limit"));
        vecs.push_back(mk(32'hFFFF_FFF9, -1, 3, 1, 1, 0, 32, 8, 1'b0, "addr_wrap"));
        vecs.push_back(mk(32'h0000_0080, -1, 0, 1, 0, 0,  0, 1, 1'b0, "nul_first"));
        vecs.push_back(mk(32'h0000_0040,  0, 0, 0, 0, 0,  0, 1, 1'b1, "err_1st"));
        vecs.push_back(mk(32'h0000_0000, -1, 2, 0, 0, 3, 25, 7, 1'b0, "start_busy"));

        repeat (2) @(negedge clk_i);
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_bvalid", byte_valid_o, 1'b0);
        check("rst_byte", byte_o, 8'h00);
        check("rst_req", |obi_req, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        foreach (vecs[i]) begin
            run(vecs[i].base, vecs[i].err_idx, vecs[i].rlat, vecs[i].gwait, vecs[i].mode,
                vecs[i].restart, vecs[i].tag);
            check({vecs[i].tag, "_tbl_nbytes"}, obs_b.size(), vecs[i].nb);
            check({vecs[i].tag, "_tbl_nreads"}, obs_a.size(), vecs[i].nr);
            check({vecs[i].tag, "_tbl_err"}, err_o, vecs[i].er);
            if (i == 0) check("first_byte_latency", first_lat, 4);
        end

        // Reset while waiting for a response; the late response must be ignored.
        cfg_rlat = 10; cfg_gwait = 0; rmode = 0;
        base_addr_i = 32'h0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        check("wait_busy", busy_o, 1'b1);
        check("wait_no_req", obi_req.req, 1'b0);
        rst_ni = 1'b0;
        #1;
        check("rst_wait_busy", busy_o, 1'b0);
        check("rst_wait_bvalid", byte_valid_o, 1'b0);
        check("rst_wait_req", |obi_req, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        obs_b.delete(); obs_done = 0;
        repeat (15) @(negedge clk_i);
        check("stray_rsp_busy", busy_o, 1'b0);
        check("stray_rsp_bytes", obs_b.size(), 0);
        check("stray_rsp_done", obs_done, 0);

        // Subordinate that never responds.
        cfg_rlat = -1; obs_done = 0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
`ifdef OBI_STR_READER_TIMEOUT_EN
        repeat (40) @(negedge clk_i);
        check("tmo_done", obs_done, 1);
        check("tmo_err", err_o, 1'b1);
        check("tmo_idle", busy_o, 1'b0);
`else
        nbusy = 0;
        repeat (100) begin
            @(negedge clk_i);
            if (busy_o) nbusy++;
        end
        check("hang_busy", nbusy, 100);
        check("hang_no_done", obs_done, 0);
`endif
        reset_pulse();

        // Random strings, bases, latencies and consumer stalls.
        for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        for (int t = 0; t < 40; t++) begin
            run($urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
